// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one main-memory port between two cache controllers. Requester 0 is
//   the instruction side and requester 1 is the data side. Arbitration is
//   round-robin. The grant is held from a write-back into the allocate read
//   that immediately follows it, so a dirty-miss refill is never interleaved
//   with the other cache's traffic. A watchdog aborts a transfer that memory
//   never completes.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rN_valid/rw/addr/wdata   requester N request (rw: 1 = write, 0 = read)
//   rN_rdata, rN_ready       read line and completion pulse to requester N
//   mem_valid/rw/addr/wdata  request forwarded to memory
//   mem_rdata, mem_ready     memory read line and transfer completion
//   grant                    one-hot current owner, 0 when idle
//   timeout_err              sticky watchdog flag, cleared only by rst
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic              r0_rw,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    input  logic              r1_valid,
    input  logic              r1_rw,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int unsigned WD_W  = (TIMEOUT + 1 <= 1) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen in the last BUSY cycle that is allowed to run without
    // mem_ready; reaching it fires the watchdog at the closing edge.
    localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              last_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic              timeout_err_q;

    logic              own_valid;
    logic              own_rw;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              winner;
    logic              busy;
    logic              wd_fire;

    always_comb begin
        own_valid = owner_q ? r1_valid : r0_valid;
        own_rw    = owner_q ? r1_rw    : r0_rw;
        own_addr  = owner_q ? r1_addr  : r0_addr;
        own_wdata = owner_q ? r1_wdata : r0_wdata;
        // On a tie the requester that did not complete last wins.
        if (r0_valid && r1_valid) begin
            winner = ~last_q;
        end else begin
            winner = r1_valid;
        end
        wd_fire = (TIMEOUT != 0) && (wd_cnt_q == WD_W'(WD_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        owner_q  <= winner;
                        wd_cnt_q <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        last_q  <= owner_q;
                        state_q <= own_rw ? LOCK : IDLE;
                    end else if (!own_valid) begin
                        state_q <= IDLE;
                    end else if (wd_fire) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                LOCK: begin
                    // Only an allocate read from the same owner keeps the port.
                    if (own_valid && !own_rw) begin
                        wd_cnt_q <= '0;
                        state_q  <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == BUSY);
        mem_valid = busy && own_valid;
        mem_rw    = busy && own_rw;
        mem_addr  = busy ? own_addr  : '0;
        mem_wdata = busy ? own_wdata : '0;
        // Readies are suppressed while rst is high so a reset cannot complete a transfer.
        r0_ready  = busy && !rst && !owner_q && mem_ready;
        r1_ready  = busy && !rst &&  owner_q && mem_ready;
        r0_rdata  = mem_rdata;
        r1_rdata  = mem_rdata;
        if (state_q == IDLE) begin
            grant = 2'b00;
        end else begin
            grant = owner_q ? 2'b10 : 2'b01;
        end
        timeout_err = timeout_err_q;
    end

endmodule
